// File: rtl/bnc_input_reader_pkg.sv
// Shared constants for the BNC input reader and its companion output driver.
// Both blocks take the channel count and default timing from here.
package bnc_input_reader_pkg;

  localparam int NUM_CH              = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 2000;
  localparam int GATE_CYCLES_DEF     = 200_000_000;
  localparam int CNT_W_DEF           = 28;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnc_debounce.sv
// One BNC channel: two-flop synchronizer, debounce counter, debounced level
// and a registered rising-edge strobe coincident with level going high.
module bnc_debounce
  import bnc_input_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit INVERT          = 1'b1
) (
  input  logic clk,
  input  logic rst_in,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam int            DW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic [DW-1:0] dcnt;

  assign s = sync2 ^ INVERT;

  // Synchronizer; reset to the idle pin level so s reads inactive.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      sync1 <= INVERT;
      sync2 <= INVERT;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Level follows s only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      level <= 1'b0;
      rise  <= 1'b0;
      dcnt  <= '0;
    end else if (s == level) begin
      rise  <= 1'b0;
      dcnt  <= '0;
    end else if (dcnt == DLAST) begin
      level <= s;
      rise  <= s;
      dcnt  <= '0;
    end else begin
      rise  <= 1'b0;
      dcnt  <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/bnc_input_reader.sv
// Four-channel BNC input reader: debounced levels, rise strobes and
// per-channel edge counts latched at the end of every gate window.
module bnc_input_reader
  import bnc_input_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int GATE_CYCLES     = GATE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter bit INVERT          = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic [NUM_CH-1:0]       bnc_in,
  output logic [NUM_CH-1:0]       level,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    count_valid
);

  localparam int            GW    = cnt_width(GATE_CYCLES);
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);

  logic [GW-1:0]    gcnt;
  logic             terminal;
  logic [CNT_W-1:0] acc     [NUM_CH];
  logic [CNT_W-1:0] acc_inc [NUM_CH];
  logic [NUM_CH-1:0] ovf_acc;
  logic [NUM_CH-1:0] ovf_inc;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bnc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT)
    ) u_deb (
      .clk   (clk),
      .rst_in(rst_in),
      .pin   (bnc_in[g]),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  assign terminal = (gcnt == GLAST);

  // Saturating increment; a rise arriving at full scale marks overflow instead.
  always_comb begin
    ovf_inc = ovf_acc;
    for (int n = 0; n < NUM_CH; n++) begin
      acc_inc[n] = acc[n];
      if (rise[n]) begin
        if (&acc[n]) begin
          ovf_inc[n] = 1'b1;
        end else begin
          acc_inc[n] = acc[n] + 1'b1;
        end
      end else begin
        acc_inc[n] = acc[n];
      end
    end
  end

  // Gate window counter, wrapping after the terminal cycle.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      gcnt <= '0;
    end else if (terminal) begin
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + 1'b1;
    end
  end

  // Accumulate; on the terminal cycle publish (including that cycle's rise) and clear.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int n = 0; n < NUM_CH; n++) begin
        acc[n] <= '0;
      end
      ovf_acc     <= '0;
      count       <= '0;
      overflow    <= '0;
      count_valid <= 1'b0;
    end else if (terminal) begin
      for (int n = 0; n < NUM_CH; n++) begin
        count[n*CNT_W +: CNT_W] <= acc_inc[n];
        acc[n]                  <= '0;
      end
      overflow    <= ovf_inc;
      ovf_acc     <= '0;
      count_valid <= 1'b1;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        acc[n] <= acc_inc[n];
      end
      ovf_acc     <= ovf_inc;
      count_valid <= 1'b0;
    end
  end

endmodule
